// File: rtl/cmd_exec.sv
// -----------------------------------------------------------------------------
// cmd_exec
//   Pops one 40-bit command word at a time from a command FIFO, performs a
//   single-word memory write or read, and pushes a byte response into a
//   response FIFO.
//
//   Command word : [39:32] opcode, [31:16] word address, [15:0] data
//   Opcodes      : 0x57 'W' write  -> response 'K' (0x4B)
//                  0x52 'R' read   -> response rdata[15:8], rdata[7:0]
//                  anything else   -> response 'E' (0x45), err_cnt++ (saturating)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_fifo_empty      command FIFO holds no words
//   cmd_fifo_rd_en      pop strobe, data arrives the following cycle
//   cmd_fifo_rd_data    popped command word
//   mem_en/mem_we       memory strobe and write select
//   mem_addr/mem_wdata  address and write data, held between strobes
//   mem_rdata           read data, valid the cycle after a read strobe
//   resp_fifo_full      response FIFO cannot take a byte
//   resp_fifo_wr_en     push strobe (combinational from resp_fifo_full)
//   resp_fifo_wr_data   response byte
//   busy                FSM outside IDLE
//   err_cnt             saturating count of illegal opcodes
//
// States
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | waiting for a command; issues the one-cycle pop strobe
//   FETCH      | popped word is on cmd_fifo_rd_data; capture it
//   DECODE     | route on opcode, launch memory strobe or error response
//   MEM_WR     | write strobe is on the bus this cycle
//   MEM_RD     | read strobe is on the bus this cycle
//   MEM_WAIT   | read data is on mem_rdata; capture it
//   RESP       | push response bytes, stalling while the FIFO is full
// -----------------------------------------------------------------------------
module cmd_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_fifo_empty,
  output logic        cmd_fifo_rd_en,
  input  logic [39:0] cmd_fifo_rd_data,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        resp_fifo_full,
  output logic        resp_fifo_wr_en,
  output logic [7:0]  resp_fifo_wr_data,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0] OP_WR    = 8'h57;
  localparam logic [7:0] OP_RD    = 8'h52;
  localparam logic [7:0] BYTE_OK  = 8'h4B;
  localparam logic [7:0] BYTE_ERR = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_WR,
    S_MEM_RD,
    S_MEM_WAIT,
    S_RESP
  } state_t;

  // Selects which byte is presented on resp_fifo_wr_data. The byte itself
  // is built from registers only, so the sole input-to-output path stays
  // resp_fifo_full -> resp_fifo_wr_en.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ERR,
    SEL_OK,
    SEL_HI,
    SEL_LO
  } resp_sel_t;

  state_t      state;
  resp_sel_t   resp_sel;
  logic [39:0] cmd_q;
  logic [15:0] rdata_q;
  logic [7:0]  opcode;
  logic        resp_accept;

  assign opcode          = cmd_q[39:32];
  assign busy            = (state != S_IDLE);
  assign resp_accept     = (state == S_RESP) && !resp_fifo_full;
  assign resp_fifo_wr_en = resp_accept;

  always_comb begin
    resp_fifo_wr_data = 8'h00;
    case (resp_sel)
      SEL_ERR: resp_fifo_wr_data = BYTE_ERR;
      SEL_OK:  resp_fifo_wr_data = BYTE_OK;
      SEL_HI:  resp_fifo_wr_data = rdata_q[15:8];
      SEL_LO:  resp_fifo_wr_data = rdata_q[7:0];
      default: resp_fifo_wr_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      resp_sel       <= SEL_NONE;
      cmd_q          <= '0;
      rdata_q        <= '0;
      cmd_fifo_rd_en <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      err_cnt        <= '0;
    end else begin
      // Strobes are single-cycle pulses unless a state re-asserts them.
      cmd_fifo_rd_en <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;

      case (state)
        S_IDLE: begin
          // IDLE spans the pop cycle itself: the pulse is raised from IDLE
          // and the move to FETCH happens as it drops, so the popped word
          // is on the bus while in FETCH.
          if (cmd_fifo_rd_en) begin
            state <= S_FETCH;
          end else if (!cmd_fifo_empty) begin
            cmd_fifo_rd_en <= 1'b1;
          end
        end

        S_FETCH: begin
          cmd_q <= cmd_fifo_rd_data;
          state <= S_DECODE;
        end

        S_DECODE: begin
          case (opcode)
            OP_WR: begin
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= cmd_q[31:16];
              mem_wdata <= cmd_q[15:0];
              state     <= S_MEM_WR;
            end
            OP_RD: begin
              mem_en   <= 1'b1;
              mem_addr <= cmd_q[31:16];
              state    <= S_MEM_RD;
            end
            default: begin
              resp_sel <= SEL_ERR;
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
              state <= S_RESP;
            end
          endcase
        end

        S_MEM_WR: begin
          resp_sel <= SEL_OK;
          state    <= S_RESP;
        end

        S_MEM_RD: begin
          state <= S_MEM_WAIT;
        end

        S_MEM_WAIT: begin
          rdata_q  <= mem_rdata;
          resp_sel <= SEL_HI;
          state    <= S_RESP;
        end

        S_RESP: begin
          // Only the high read byte has a successor; every other byte is last.
          if (resp_accept) begin
            if (resp_sel == SEL_HI) begin
              resp_sel <= SEL_LO;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_exec.sv
// -----------------------------------------------------------------------------
// tb_cmd_exec
//   Drives cmd_exec from a modelled command FIFO and memory, logs every pop,
//   memory strobe and response push, and compares the logs against a
//   command-level reference model (memory image + expected response bytes +
//   cycle offsets from the pop strobe).
// -----------------------------------------------------------------------------
module tb_cmd_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_fifo_empty;
  logic        cmd_fifo_rd_en;
  logic [39:0] cmd_fifo_rd_data = '0;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        resp_fifo_full = 1'b0;
  logic        resp_fifo_wr_en;
  logic [7:0]  resp_fifo_wr_data;
  logic        busy;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  cmd_exec dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_fifo_empty    (cmd_fifo_empty),
    .cmd_fifo_rd_en    (cmd_fifo_rd_en),
    .cmd_fifo_rd_data  (cmd_fifo_rd_data),
    .mem_en            (mem_en),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .resp_fifo_full    (resp_fifo_full),
    .resp_fifo_wr_en   (resp_fifo_wr_en),
    .resp_fifo_wr_data (resp_fifo_wr_data),
    .busy              (busy),
    .err_cnt           (err_cnt)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int viol   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Command FIFO environment
  logic [39:0] cmd_mem [0:1023];
  logic [9:0]  wr_ptr = '0;
  logic [9:0]  rd_ptr = '0;

  assign cmd_fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (cmd_fifo_rd_en) begin
      cmd_fifo_rd_data <= cmd_mem[rd_ptr];
      rd_ptr           <= rd_ptr + 10'd1;
    end
  end

  // Memory environment: preloaded image plus whatever the DUT writes
  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0010 || a == 16'h0020) return 16'h1234;
    return {a[7:0] ^ 8'h5A, ~a[7:0]};
  endfunction

  logic [15:0] env_mem [0:65535];
  bit          env_wr  [0:65535];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        env_mem[mem_addr] <= mem_wdata;
        env_wr[mem_addr]  <= 1'b1;
      end else begin
        mem_rdata <= env_wr[mem_addr] ? env_mem[mem_addr] : init_val(mem_addr);
      end
    end
  end

  // Event logs, sampled mid-cycle
  typedef struct {
    int          c;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_ev_t;

  typedef struct {
    int         c;
    logic [7:0] b;
  } push_ev_t;

  mem_ev_t  mem_log [$];
  push_ev_t push_log [$];
  int       rd_cyc [$];

  always @(negedge clk) begin : mon
    mem_ev_t  me;
    push_ev_t pe;
    if (cmd_fifo_rd_en) rd_cyc.push_back(cyc);
    if (mem_en) begin
      me.c = cyc; me.we = mem_we; me.addr = mem_addr; me.wdata = mem_wdata;
      mem_log.push_back(me);
    end
    if (resp_fifo_wr_en) begin
      pe.c = cyc; pe.b = resp_fifo_wr_data;
      push_log.push_back(pe);
    end
    viol <= viol + int'(cmd_fifo_rd_en && (busy || cmd_fifo_empty))
                 + int'(resp_fifo_wr_en && resp_fifo_full)
                 + int'(mem_we && !mem_en);
  end

  // Reference model state
  logic [15:0] ref_mem [0:65535];
  bit          ref_wr  [0:65535];
  int          err_model = 0;
  logic [39:0] bq [$];
  int          rd_base, mem_base, push_base, viol_base;

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_batch();
    rd_base   = rd_cyc.size();
    mem_base  = mem_log.size();
    push_base = push_log.size();
    viol_base = viol;
    bq.delete();
  endtask

  task automatic issue(input logic [39:0] w, input bit expected);
    cmd_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 10'd1;
    if (expected) bq.push_back(w);
  endtask

  task automatic wait_rd(output int t);
    int n = 0;
    while (!cmd_fifo_rd_en && n < 100) begin
      step();
      n++;
    end
    chk("rd_en_wait", 64'(cmd_fifo_rd_en), 64'd1);
    t = cyc;
  endtask

  task automatic wait_done(input int limit, input bit rand_bp);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < limit) begin
      step();
      n++;
      if (rand_bp) resp_fifo_full = ($urandom_range(0, 2) == 0);
      if (cmd_fifo_empty && !busy && !cmd_fifo_rd_en) quiet++;
      else quiet = 0;
    end
    resp_fifo_full = 1'b0;
    chk("done_in_budget", 64'(n < limit), 64'd1);
    step();
  endtask

  task automatic chk_mem(input int idx, input logic we, input logic [15:0] a,
                         input logic [15:0] d, input bit chk_wd, input int tc,
                         input bit timing);
    if (idx >= mem_log.size()) begin
      chk("mem_strobe_present", 64'(mem_log.size()), 64'(idx + 1));
    end else begin
      chk("mem_we", 64'(mem_log[idx].we), 64'(we));
      chk("mem_addr", 64'(mem_log[idx].addr), 64'(a));
      if (chk_wd) chk("mem_wdata", 64'(mem_log[idx].wdata), 64'(d));
      if (timing) chk("mem_strobe_cycle", 64'(mem_log[idx].c), 64'(tc));
    end
  endtask

  task automatic chk_push(input int idx, input logic [7:0] b, input int tc, input bit timing);
    if (idx >= push_log.size()) begin
      chk("push_present", 64'(push_log.size()), 64'(idx + 1));
    end else begin
      chk("push_byte", 64'(push_log[idx].b), 64'(b));
      if (timing) chk("push_cycle", 64'(push_log[idx].c), 64'(tc));
    end
  endtask

  // Walk the batch in command order; the n-th pop belongs to the n-th command.
  task automatic verify(input bit timing);
    int mi = mem_base;
    int pi = push_base;
    int t;
    int gap;
    logic [7:0]  op;
    logic [15:0] a, d, rv;
    for (int i = 0; i < bq.size(); i++) begin
      op = bq[i][39:32];
      a  = bq[i][31:16];
      d  = bq[i][15:0];
      if (rd_base + i >= rd_cyc.size()) begin
        chk("pop_count_short", 64'(rd_cyc.size() - rd_base), 64'(bq.size()));
        break;
      end
      t = rd_cyc[rd_base + i];
      gap = 0;
      if (op == 8'h57) begin
        chk_mem(mi, 1'b1, a, d, 1'b1, t + 3, timing);
        mi++;
        chk_push(pi, 8'h4B, t + 4, timing);
        pi++;
        ref_mem[a] = d;
        ref_wr[a]  = 1'b1;
        gap = 5;
      end else if (op == 8'h52) begin
        rv = ref_read(a);
        chk_mem(mi, 1'b0, a, 16'h0000, 1'b0, t + 3, timing);
        mi++;
        chk_push(pi, rv[15:8], t + 5, timing);
        chk_push(pi + 1, rv[7:0], t + 6, timing);
        pi += 2;
        gap = 7;
      end else begin
        chk_push(pi, 8'h45, t + 3, 1'b0);
        pi++;
        err_model = (err_model == 255) ? 255 : err_model + 1;
      end
      if (timing && gap > 0 && rd_base + i + 1 < rd_cyc.size())
        chk("next_pop_gap", 64'(rd_cyc[rd_base + i + 1] >= t + gap), 64'd1);
    end
    chk("pop_count", 64'(rd_cyc.size() - rd_base), 64'(bq.size()));
    chk("mem_strobe_count", 64'(mem_log.size() - mem_base), 64'(mi - mem_base));
    chk("push_count", 64'(push_log.size() - push_base), 64'(pi - push_base));
    chk("protocol_violations", 64'(viol - viol_base), 64'd0);
    chk("err_cnt", 64'(err_cnt), 64'(err_model));
  endtask

  function automatic logic [39:0] rand_cmd();
    int unsigned r;
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] d;
    r = $urandom_range(0, 9);
    if (r < 4) begin
      op = 8'h57;
    end else if (r < 8) begin
      op = 8'h52;
    end else begin
      op = 8'($urandom_range(0, 255));
      if (op == 8'h57 || op == 8'h52) op = 8'h00;
    end
    a = 16'($urandom_range(0, 31));
    d = 16'($urandom);
    return {op, a, d};
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    int t_rel;
    int p0;
    logic [7:0] op;

    for (int i = 0; i < 65536; i++) ref_wr[i] = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_en", 64'(cmd_fifo_rd_en), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_wr_en", 64'(resp_fifo_wr_en), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_wr_data", 64'(resp_fifo_wr_data), 64'd0);

    // Read 0x0010 (preloaded 0x1234), queued while still in reset
    begin_batch();
    issue(40'h52_0010_0000, 1'b1);
    step();
    chk("rd_en_held_in_rst", 64'(cmd_fifo_rd_en), 64'd0);
    t_rel = cyc;
    rst = 1'b0;
    wait_done(200, 1'b0);
    if (rd_cyc.size() > rd_base)
      chk("first_pop_after_rst", 64'(rd_cyc[rd_base] > t_rel), 64'd1);
    verify(1'b1);

    // Write 0xBEEF to 0x0010
    begin_batch();
    issue(40'h57_0010_BEEF, 1'b1);
    wait_done(200, 1'b0);
    verify(1'b1);
    chk("busy_after_write", 64'(busy), 64'd0);

    // Single illegal opcode, then 300 more to reach saturation
    begin_batch();
    issue(40'h41_0000_0000, 1'b1);
    wait_done(200, 1'b0);
    verify(1'b1);

    begin_batch();
    for (int i = 0; i < 300; i++) begin
      op = 8'($urandom_range(0, 255));
      if (op == 8'h57 || op == 8'h52) op = 8'hFF;
      issue({op, 16'($urandom), 16'($urandom)}, 1'b1);
    end
    wait_done(5000, 1'b0);
    verify(1'b1);
    chk("err_cnt_saturated", 64'(err_cnt), 64'hFF);

    // Backpressure during a read response
    begin_batch();
    issue(40'h52_0020_0000, 1'b1);
    wait_rd(t);
    repeat (2) step();
    resp_fifo_full = 1'b1;
    p0 = push_log.size();
    repeat (10) step();
    chk("no_push_while_full", 64'(push_log.size() - p0), 64'd0);
    resp_fifo_full = 1'b0;
    wait_done(200, 1'b0);
    verify(1'b0);

    // Back-to-back W / R / W
    begin_batch();
    issue(40'h57_0030_1111, 1'b1);
    issue(40'h52_0030_0000, 1'b1);
    issue(40'h57_0031_2222, 1'b1);
    wait_done(300, 1'b0);
    verify(1'b1);

    // Reset while in MEM_WAIT abandons the read; the queued write still runs
    begin_batch();
    issue(40'h52_0005_0000, 1'b0);
    issue(40'h57_0006_CAFE, 1'b1);
    wait_rd(t);
    repeat (4) step();
    chk("busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_mem_en", 64'(mem_en), 64'd0);
    chk("mid_rst_rd_en", 64'(cmd_fifo_rd_en), 64'd0);
    chk("mid_rst_wr_en", 64'(resp_fifo_wr_en), 64'd0);
    chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("mid_rst_wr_data", 64'(resp_fifo_wr_data), 64'd0);
    chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("mid_rst_no_push", 64'(push_log.size() - push_base), 64'd0);
    err_model = 0;
    rst = 1'b0;
    rd_base   = rd_cyc.size();
    mem_base  = mem_log.size();
    push_base = push_log.size();
    viol_base = viol;
    wait_done(200, 1'b0);
    verify(1'b1);

    // Randomized batches, the last two under random backpressure
    for (int b = 0; b < 3; b++) begin
      begin_batch();
      for (int i = 0; i < 20; i++) issue(rand_cmd(), 1'b1);
      wait_done(2000, b != 0);
      verify(b == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
